// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, level status flags.
// Optional 2-of-3 majority sampling of start/data bits: define UART_RX_MAJORITY_EN.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk50m,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_error,
  output logic       rx_idle
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_OFS = 1;  // decide one clock late, once mid-bit+1 is visible
`else
  localparam int SAMPLE_OFS = 0;
`endif
  localparam logic [8:0] START_LAST = 9'(HALF_BIT - 1 + SAMPLE_OFS);
  localparam logic [8:0] BIT_LAST   = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] WIN_FIRST  = 9'(HALF_BIT - 1 - SAMPLE_OFS);
  localparam logic [8:0] STOP_LAST  = 9'(CLKS_PER_BIT - 2 - SAMPLE_OFS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  sync_r;
  logic        prev_r;
  logic [8:0]  cnt_r, cnt_s;
  logic [2:0]  bit_r, bit_s;
  logic [7:0]  shift_r, shift_s;
  logic        ferr_r, ferr_s;
  logic [7:0]  data_r, data_s;
  logic        ready_r, ready_s;
  logic        error_r, error_s;
  logic        idle_r;
  logic        rxs_s;
  logic        sample_s;

  assign rxs_s = sync_r[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_r;

  // Two-deep history of rxs: hist_r[1] = mid-bit-1, hist_r[0] = mid-bit at decision time.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], rxs_s};
    end
  end

  assign sample_s = maj3(hist_r[1], hist_r[0], rxs_s);
`else
  assign sample_s = rxs_s;
`endif

  // Next-state, counters, shift register and output updates.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + 9'd1;
    bit_s   = bit_r;
    shift_s = shift_r;
    ferr_s  = ferr_r;
    data_s  = data_r;
    ready_s = ready_r;
    error_s = error_r;
    case (state_r)
      IDLE: begin
        cnt_s = 9'd0;
        if (prev_r && !rxs_s) begin
          state_s = START;
          bit_s   = 3'd0;
          ready_s = 1'b0;
          error_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == START_LAST) begin
          cnt_s   = 9'd0;
          state_s = sample_s ? IDLE : DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = 9'd0;
          shift_s = {sample_s, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_s = STOP;
            ferr_s  = 1'b0;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        // First half of the stop count is still the tail of bit 7.
        if (cnt_r >= WIN_FIRST && !rxs_s) begin
          ferr_s = 1'b1;
        end else begin
          ferr_s = ferr_r;
        end
        if (cnt_r == STOP_LAST) begin
          state_s = IDLE;
          if (ferr_s) begin
            data_s  = 8'h00;
            ready_s = 1'b0;
            error_s = 1'b1;
          end else begin
            data_s  = shift_r;
            ready_s = 1'b1;
            error_s = 1'b0;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sync_r  <= 2'b11;
      prev_r  <= 1'b1;
      cnt_r   <= 9'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      ferr_r  <= 1'b0;
      data_r  <= 8'h00;
      ready_r <= 1'b0;
      error_r <= 1'b0;
      idle_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      sync_r  <= {sync_r[0], rx};
      prev_r  <= rxs_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      ferr_r  <= ferr_s;
      data_r  <= data_s;
      ready_r <= ready_s;
      error_r <= error_s;
      idle_r  <= (state_s == IDLE);
    end
  end

  assign rx_data  = data_r;
  assign rx_ready = ready_r;
  assign rx_error = error_r;
  assign rx_idle  = idle_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, framing error, false start, reset mid-frame.
module tb_uart_rx;

  localparam int BIT_NS = 8670;

  logic       clk50m = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_error;
  logic       rx_idle;

  int vectors = 0;
  int miscompares = 0;

  uart_rx dut (
    .clk50m  (clk50m),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .rx_error(rx_error),
    .rx_idle (rx_idle)
  );

  always #10 clk50m = ~clk50m;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic rdy,
                               input logic err, input logic idl);
    check({tag, ".data"},  rx_data, d);
    check({tag, ".ready"}, {7'd0, rx_ready}, {7'd0, rdy});
    check({tag, ".error"}, {7'd0, rx_error}, {7'd0, err});
    check({tag, ".idle"},  {7'd0, rx_idle},  {7'd0, idl});
  endtask

  // Sends one 8N1 frame; optional 2-clock low glitch 2 us into the stop bit.
  // Ends 10 us after the stop bit begins. Mid-frame the receiver must be busy with flags cleared.
  task automatic send_frame(input string tag, input logic [7:0] b, input bit glitch);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
      if (i == 1) begin
        check({tag, ".busy_ready"}, {7'd0, rx_ready}, 8'd0);
        check({tag, ".busy_error"}, {7'd0, rx_error}, 8'd0);
        check({tag, ".busy_idle"},  {7'd0, rx_idle},  8'd0);
      end
    end
    rx = 1'b1;
    if (glitch) begin
      #2000;
      rx = 1'b0;
      #40;
      rx = 1'b1;
      #7960;
    end else begin
      #10000;
    end
  endtask

  initial begin
    #3;
    rst_n = 1'b0;
    rx    = 1'b0;
    #1000;
    check_outputs("in_reset", 8'h00, 1'b0, 1'b0, 1'b1);
    rx    = 1'b1;
    rst_n = 1'b1;
    #20000;
    check_outputs("after_reset", 8'h00, 1'b0, 1'b0, 1'b1);

    send_frame("f55", 8'h55, 1'b0);
    check_outputs("f55", 8'h55, 1'b1, 1'b0, 1'b1);

    send_frame("f55_glitch", 8'h55, 1'b1);
    check_outputs("f55_glitch", 8'h00, 1'b0, 1'b1, 1'b1);

    send_frame("fAB", 8'hAB, 1'b0);
    check_outputs("fAB", 8'hAB, 1'b1, 1'b0, 1'b1);

    rx = 1'b0;
    #2000;
    rx = 1'b1;
    #20000;
    check_outputs("false_start", 8'hAB, 1'b0, 1'b0, 1'b1);

    // 0x3C interrupted by reset after bit 3 (bits 0..3 = 0,0,1,1).
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = ((i == 2) || (i == 3)) ? 1'b1 : 1'b0;
      #(BIT_NS);
    end
    check({"mid_reset_busy"}, {7'd0, rx_idle}, 8'd0);
    rst_n = 1'b0;
    #1000;
    check_outputs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b1);
    rx    = 1'b1;
    rst_n = 1'b1;
    #20000;
    check_outputs("mid_reset_release", 8'h00, 1'b0, 1'b0, 1'b1);

    send_frame("f3C", 8'h3C, 1'b0);
    check_outputs("f3C", 8'h3C, 1'b1, 1'b0, 1'b1);

    send_frame("f80", 8'h80, 1'b0);
    check_outputs("f80", 8'h80, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
